// File: rtl/ein_pkg.sv
// ein_pkg: shared constants, state encoding and symbol codes for the EIN demodulator.
//   DEF_FILTER_CYCLES  - default stability-filter length (clk cycles)
//   DEF_TIMEOUT_CYCLES - default idle-symbol limit inside a frame
//   DEF_CNT_WIDTH      - default timeout counter width
//   state_e / sym_e    - receiver state and per-cycle symbol classification
package ein_pkg;

    localparam int unsigned DEF_FILTER_CYCLES  = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 8000;
    localparam int unsigned DEF_CNT_WIDTH      = 14;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned BCNT_W             = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SYM_NONE  = 3'd0,
        SYM_MARK  = 3'd1,
        SYM_ONE   = 3'd2,
        SYM_ZERO  = 3'd3,
        SYM_MULTI = 3'd4
    } sym_e;

    // Fold the three line events of one cycle into a single symbol code.
    function automatic sym_e classify(input logic mark, input logic one, input logic zero);
        sym_e s;
        unique case ({mark, one, zero})
            3'b000:  s = SYM_NONE;
            3'b100:  s = SYM_MARK;
            3'b010:  s = SYM_ONE;
            3'b001:  s = SYM_ZERO;
            default: s = SYM_MULTI;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ein_demod_if.sv
// ein_demod_if: pad inputs and frame outputs of the EIN demodulator.
//   EMO_PAD/EDI_PAD/ECI_PAD - asynchronous pad lines (mark / bit 1 / bit 0)
//   out_frame_data          - last completed byte
//   out_frame_data_latch    - one-cycle strobe, out_frame_data valid
//   out_frame_valid         - frame in progress
//   rx_done / rx_error      - one-cycle clean-end / abort pulses
// master drives the pads, slave is the demodulator.
interface ein_demod_if
    import ein_pkg::*;
;
    logic              EMO_PAD;
    logic              EDI_PAD;
    logic              ECI_PAD;
    logic [BYTE_W-1:0] out_frame_data;
    logic              out_frame_data_latch;
    logic              out_frame_valid;
    logic              rx_done;
    logic              rx_error;

    modport master (
        output EMO_PAD, EDI_PAD, ECI_PAD,
        input  out_frame_data, out_frame_data_latch, out_frame_valid, rx_done, rx_error
    );

    modport slave (
        input  EMO_PAD, EDI_PAD, ECI_PAD,
        output out_frame_data, out_frame_data_latch, out_frame_valid, rx_done, rx_error
    );

endinterface

// File: rtl/ein_line_filter.sv
// ein_line_filter: 2-flop synchronizer, stability filter and edge detector for one pad.
//   clk     - clock
//   pad_i   - asynchronous pad level
//   event_o - one-cycle pulse when the filtered level changes
// Not reset: it keeps running through reset so the reference always matches the
// filtered level and reset release cannot produce a false event.
module ein_line_filter
    import ein_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic pad_i,
    output logic event_o
);

    localparam int unsigned FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic              sync1_q;
    logic              sync2_q;
    logic              level_q;
    logic              level_d;
    logic              ref_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;

    // Synchronizer, filter state and reference.
    always_ff @(posedge clk) begin
        sync1_q <= pad_i;
        sync2_q <= sync1_q;
        fcnt_q  <= fcnt_d;
        level_q <= level_d;
        ref_q   <= level_q;
    end

    // Count consecutive samples that disagree with the filtered level; accept on the last one.
    always_comb begin
        level_d = level_q;
        fcnt_d  = '0;
        if (sync2_q != level_q) begin
            if (fcnt_q == FCNT_W'(FILTER_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign event_o = level_q ^ ref_q;

endmodule

// File: rtl/ein_demod.sv
// ein_demod: EIN three-line toggle demodulator (EMO marks frames, EDI = 1, ECI = 0).
//   clk    - clock, all logic on posedge
//   resetn - synchronous active-low reset
//   bus    - ein_demod_if.slave: pad inputs and registered frame outputs
// Optional: EIN_DEMOD_TIMEOUT_EN builds an idle-symbol timeout that aborts a frame.
module ein_demod
    import ein_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic        clk,
    input  logic        resetn,
    ein_demod_if.slave  bus
);

    // Elaboration guard on the timeout counter width.
    if (CNT_WIDTH < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_width_check
        $error("ein_demod: CNT_WIDTH too small for TIMEOUT_CYCLES");
    end

    logic mark_ev;
    logic one_ev;
    logic zero_ev;
    sym_e sym;

    ein_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_emo (.clk(clk), .pad_i(bus.EMO_PAD), .event_o(mark_ev));
    ein_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_edi (.clk(clk), .pad_i(bus.EDI_PAD), .event_o(one_ev));
    ein_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_eci (.clk(clk), .pad_i(bus.ECI_PAD), .event_o(zero_ev));

    assign sym = classify(mark_ev, one_ev, zero_ev);

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                latch_q, latch_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                timeout;

`ifdef EIN_DEMOD_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

    // Last idle cycle before the limit is reached.
    assign timeout = (state_q == ST_RECEIVE) && (sym == SYM_NONE)
                  && (tcnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            shift_q <= '0;
            bcnt_q  <= '0;
            latch_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef EIN_DEMOD_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            latch_q <= latch_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef EIN_DEMOD_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sym == SYM_MARK) begin
                    state_d = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if ((sym == SYM_MARK) || (sym == SYM_MULTI) || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        data_d  = data_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        latch_d = 1'b0;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef EIN_DEMOD_TIMEOUT_EN
        tcnt_d  = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Simultaneous events in IDLE are dropped; only a lone mark opens a frame.
                if (sym == SYM_MARK) begin
                    valid_d = 1'b1;
                    bcnt_d  = '0;
                    shift_d = '0;
                end
            end
            ST_RECEIVE: begin
                unique case (sym)
                    SYM_ONE, SYM_ZERO: begin
                        shift_d = {shift_q[BYTE_W-2:0], (sym == SYM_ONE)};
                        bcnt_d  = bcnt_q + BCNT_W'(1);
                        if (bcnt_q == BCNT_W'(BYTE_W - 1)) begin
                            data_d  = shift_d;
                            latch_d = 1'b1;
                        end
                    end
                    SYM_MARK: begin
                        valid_d = 1'b0;
                        if (bcnt_q == '0) begin
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    SYM_MULTI: begin
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                    end
                    default: begin
                        if (timeout) begin
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                        end
`ifdef EIN_DEMOD_TIMEOUT_EN
                        else begin
                            tcnt_d = tcnt_q + CNT_WIDTH'(1);
                        end
`endif
                    end
                endcase
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.out_frame_data       = data_q;
    assign bus.out_frame_data_latch = latch_q;
    assign bus.out_frame_valid      = valid_q;
    assign bus.rx_done              = done_q;
    assign bus.rx_error             = err_q;

endmodule
